// File: rtl/dcache_bank_arbiter.sv
// Round-robin arbiter sharing NUM_BANKS dcache banks among NUM_CONSUMERS
// load/store requesters. Each bank serves one outstanding request at a time.
// A consumer presents at most one request (read before write), so it can
// never be granted by two banks in the same cycle.
module dcache_bank_arbiter #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int NUM_CONSUMERS    = 8,
  parameter int NUM_BANKS        = 2,
  parameter int CACHE_BLOCK_SIZE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_BANKS-1:0]     bank_req_valid,
  output logic [NUM_BANKS-1:0]     bank_req_write,
  output logic [ADDR_BITS-1:0]     bank_req_address       [NUM_BANKS],
  output logic [DATA_BITS-1:0]     bank_req_data          [NUM_BANKS],
  input  logic [NUM_BANKS-1:0]     bank_req_ready,
  input  logic [NUM_BANKS-1:0]     bank_resp_valid,
  input  logic [DATA_BITS-1:0]     bank_resp_data         [NUM_BANKS]
);

  localparam int BB = $clog2(NUM_BANKS);
  localparam int OB = $clog2(CACHE_BLOCK_SIZE);
  localparam int CB = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {C_IDLE, C_PEND, C_DONE} cons_state_t;
  typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bank_state_t;

  // Consumer state
  cons_state_t            cons_state_reg [NUM_CONSUMERS];
  cons_state_t            cons_state_next[NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] cons_write_reg, cons_write_next;
  logic [DATA_BITS-1:0]   rdata_reg      [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]   rdata_next     [NUM_CONSUMERS];

  // Bank state
  bank_state_t            bank_state_reg [NUM_BANKS];
  bank_state_t            bank_state_next[NUM_BANKS];
  logic [CB-1:0]          rr_ptr_reg     [NUM_BANKS];
  logic [CB-1:0]          rr_ptr_next    [NUM_BANKS];
  logic [CB-1:0]          winner_reg     [NUM_BANKS];
  logic [CB-1:0]          winner_next    [NUM_BANKS];
  logic [NUM_BANKS-1:0]   req_valid_reg, req_valid_next;
  logic [NUM_BANKS-1:0]   req_write_reg, req_write_next;
  logic [ADDR_BITS-1:0]   req_addr_reg   [NUM_BANKS];
  logic [ADDR_BITS-1:0]   req_addr_next  [NUM_BANKS];
  logic [DATA_BITS-1:0]   req_data_reg   [NUM_BANKS];
  logic [DATA_BITS-1:0]   req_data_next  [NUM_BANKS];

  // Arbitration and fan-in wiring
  logic [NUM_CONSUMERS-1:0] eligible;
  logic [NUM_CONSUMERS-1:0] req_write;
  logic [BB-1:0]            req_bank   [NUM_CONSUMERS];
  logic [NUM_BANKS-1:0]     grant_hit;
  logic [CB-1:0]            grant_idx  [NUM_BANKS];
  logic [NUM_CONSUMERS-1:0] cons_grant;
  logic [NUM_CONSUMERS-1:0] cons_done;
  logic [DATA_BITS-1:0]     cons_resp  [NUM_CONSUMERS];
  logic [CB-1:0]            idx;

  // Each idle consumer offers its read if present, otherwise its write
  always_comb begin
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      req_write[c] = !consumer_read_valid[c];
      req_bank[c]  = consumer_read_valid[c] ? consumer_read_address[c][OB +: BB]
                                            : consumer_write_address[c][OB +: BB];
      eligible[c]  = (cons_state_reg[c] == C_IDLE) &&
                     (consumer_read_valid[c] || consumer_write_valid[c]);
    end
  end

  // Per idle bank, pick the first eligible consumer at or after rr_ptr+1
  always_comb begin
    idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      grant_hit[b] = 1'b0;
      grant_idx[b] = '0;
      if (bank_state_reg[b] == B_IDLE) begin
        for (int k = 1; k <= NUM_CONSUMERS; k++) begin
          idx = rr_ptr_reg[b] + CB'(k);
          if (!grant_hit[b] && eligible[idx] && (req_bank[idx] == BB'(b))) begin
            grant_hit[b] = 1'b1;
            grant_idx[b] = idx;
          end
        end
      end
    end
  end

  // Route bank grants and responses back to the owning consumers
  always_comb begin
    cons_grant = '0;
    cons_done  = '0;
    for (int c = 0; c < NUM_CONSUMERS; c++) cons_resp[c] = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_hit[b]) cons_grant[grant_idx[b]] = 1'b1;
      if ((bank_state_reg[b] == B_WAIT) && bank_resp_valid[b]) begin
        cons_done[winner_reg[b]] = 1'b1;
        cons_resp[winner_reg[b]] = bank_resp_data[b];
      end
    end
  end

  // Bank FSM next-state: IDLE -> REQ -> WAIT -> IDLE
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_state_next[b] = bank_state_reg[b];
      rr_ptr_next[b]     = rr_ptr_reg[b];
      winner_next[b]     = winner_reg[b];
      req_valid_next[b]  = req_valid_reg[b];
      req_write_next[b]  = req_write_reg[b];
      req_addr_next[b]   = req_addr_reg[b];
      req_data_next[b]   = req_data_reg[b];
      case (bank_state_reg[b])
        B_IDLE: if (grant_hit[b]) begin
          rr_ptr_next[b]     = grant_idx[b];
          winner_next[b]     = grant_idx[b];
          req_valid_next[b]  = 1'b1;
          req_write_next[b]  = req_write[grant_idx[b]];
          req_addr_next[b]   = req_write[grant_idx[b]] ? consumer_write_address[grant_idx[b]]
                                                       : consumer_read_address[grant_idx[b]];
          req_data_next[b]   = req_write[grant_idx[b]] ? consumer_write_data[grant_idx[b]] : '0;
          bank_state_next[b] = B_REQ;
        end
        B_REQ: if (bank_req_ready[b]) begin
          req_valid_next[b]  = 1'b0;
          bank_state_next[b] = B_WAIT;
        end
        B_WAIT: if (bank_resp_valid[b]) bank_state_next[b] = B_IDLE;
        default: bank_state_next[b] = B_IDLE;
      endcase
    end
  end

  // Consumer FSM next-state: IDLE -> PEND -> DONE -> IDLE
  always_comb begin
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      cons_state_next[c] = cons_state_reg[c];
      cons_write_next[c] = cons_write_reg[c];
      rdata_next[c]      = rdata_reg[c];
      case (cons_state_reg[c])
        C_IDLE: if (cons_grant[c]) begin
          cons_state_next[c] = C_PEND;
          cons_write_next[c] = req_write[c];
        end
        C_PEND: if (cons_done[c]) begin
          cons_state_next[c] = C_DONE;
          if (!cons_write_reg[c]) rdata_next[c] = cons_resp[c];
        end
        C_DONE: begin
          if (cons_write_reg[c] ? !consumer_write_valid[c] : !consumer_read_valid[c])
            cons_state_next[c] = C_IDLE;
        end
        default: cons_state_next[c] = C_IDLE;
      endcase
    end
  end

  // State registers for all banks and consumers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_reg[b] <= B_IDLE;
        rr_ptr_reg[b]     <= '0;
        winner_reg[b]     <= '0;
        req_addr_reg[b]   <= '0;
        req_data_reg[b]   <= '0;
      end
      req_valid_reg  <= '0;
      req_write_reg  <= '0;
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        cons_state_reg[c] <= C_IDLE;
        rdata_reg[c]      <= '0;
      end
      cons_write_reg <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_reg[b] <= bank_state_next[b];
        rr_ptr_reg[b]     <= rr_ptr_next[b];
        winner_reg[b]     <= winner_next[b];
        req_addr_reg[b]   <= req_addr_next[b];
        req_data_reg[b]   <= req_data_next[b];
      end
      req_valid_reg  <= req_valid_next;
      req_write_reg  <= req_write_next;
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        cons_state_reg[c] <= cons_state_next[c];
        rdata_reg[c]      <= rdata_next[c];
      end
      cons_write_reg <= cons_write_next;
    end
  end

  // Ready is a direct decode of the registered DONE state
  always_comb begin
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      consumer_read_ready[c]  = (cons_state_reg[c] == C_DONE) && !cons_write_reg[c];
      consumer_write_ready[c] = (cons_state_reg[c] == C_DONE) &&  cons_write_reg[c];
    end
  end

  assign consumer_read_data = rdata_reg;
  assign bank_req_valid     = req_valid_reg;
  assign bank_req_write     = req_write_reg;
  assign bank_req_address   = req_addr_reg;
  assign bank_req_data      = req_data_reg;

endmodule

// File: tb/tb_dcache_bank_arbiter.sv
// Directed bench for dcache_bank_arbiter: table of single transactions plus
// hand-written contention, parallel-bank, backpressure and reset sequences.
module tb_dcache_bank_arbiter;

  localparam int NC = 8;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] rd_valid, wr_valid, rd_ready, wr_ready;
  logic [7:0]    rd_addr [NC];
  logic [7:0]    wr_addr [NC];
  logic [7:0]    wr_data [NC];
  logic [7:0]    rd_data [NC];
  logic [NB-1:0] b_valid, b_write, b_ready, b_resp_valid;
  logic [7:0]    b_addr [NB];
  logic [7:0]    b_data [NB];
  logic [7:0]    b_resp_data [NB];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_bank_arbiter dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rd_valid), .consumer_read_address(rd_addr),
    .consumer_read_ready(rd_ready), .consumer_read_data(rd_data),
    .consumer_write_valid(wr_valid), .consumer_write_address(wr_addr),
    .consumer_write_data(wr_data), .consumer_write_ready(wr_ready),
    .bank_req_valid(b_valid), .bank_req_write(b_write),
    .bank_req_address(b_addr), .bank_req_data(b_data),
    .bank_req_ready(b_ready), .bank_resp_valid(b_resp_valid),
    .bank_resp_data(b_resp_data)
  );

  typedef struct {
    int         c;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] resp;
    int         bank;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Wait (bounded) for a request on bank b, check it, accept it, then respond
  task automatic serve(input int b, input logic [7:0] exp_addr, input logic [7:0] resp,
                       input string name);
    int n = 0;
    while (b_valid[b] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({name, "_req_valid"}, 32'(b_valid[b]), 32'd1);
    check({name, "_req_addr"}, 32'(b_addr[b]), 32'(exp_addr));
    b_ready[b] = 1'b1;
    tick();
    b_ready[b] = 1'b0;
    b_resp_valid[b] = 1'b1;
    b_resp_data[b] = resp;
    tick();
    b_resp_valid[b] = 1'b0;
    b_resp_data[b] = '0;
  endtask

  task automatic clear_inputs();
    rd_valid = '0; wr_valid = '0; b_ready = '0; b_resp_valid = '0;
    for (int i = 0; i < NC; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    for (int i = 0; i < NB; i++) b_resp_data[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] acc;
    logic [1:0] expv;
    logic [7:0] onehot;
    vec_t v;

    vecs[0] = '{c: 0, wr: 1'b0, addr: 8'h05, wdata: 8'h00, resp: 8'hAB, bank: 1};
    vecs[1] = '{c: 3, wr: 1'b1, addr: 8'h02, wdata: 8'h5A, resp: 8'h00, bank: 0};
    vecs[2] = '{c: 7, wr: 1'b0, addr: 8'hFE, wdata: 8'h00, resp: 8'h3C, bank: 0};
    vecs[3] = '{c: 4, wr: 1'b1, addr: 8'h81, wdata: 8'hC3, resp: 8'h00, bank: 1};
    vecs[4] = '{c: 6, wr: 1'b0, addr: 8'hFF, wdata: 8'h00, resp: 8'h77, bank: 1};

    // Reset with random inputs
    rd_valid = NC'($urandom); wr_valid = NC'($urandom);
    b_ready = NB'($urandom); b_resp_valid = NB'($urandom);
    for (int i = 0; i < NC; i++) begin
      rd_addr[i] = 8'($urandom); wr_addr[i] = 8'($urandom); wr_data[i] = 8'($urandom);
    end
    for (int i = 0; i < NB; i++) b_resp_data[i] = 8'($urandom);
    tick();
    tick();
    check("rst_req_valid", 32'(b_valid), 32'd0);
    check("rst_req_write", 32'(b_write), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    acc = '0;
    for (int i = 0; i < NB; i++) acc = acc | b_addr[i] | b_data[i];
    for (int i = 0; i < NC; i++) acc = acc | rd_data[i];
    check("rst_data_buses", 32'(acc), 32'd0);
    clear_inputs();
    reset = 1'b0;
    tick();

    // Table of single transactions at minimum latency
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      expv = 2'(1 << v.bank);
      onehot = 8'(1 << v.c);
      if (v.wr) begin
        wr_valid[v.c] = 1'b1; wr_addr[v.c] = v.addr; wr_data[v.c] = v.wdata;
      end else begin
        rd_valid[v.c] = 1'b1; rd_addr[v.c] = v.addr;
      end
      tick();
      check($sformatf("v%0d_req_valid", i), 32'(b_valid), 32'(expv));
      check($sformatf("v%0d_req_write", i), 32'(b_write[v.bank]), 32'(v.wr));
      check($sformatf("v%0d_req_addr", i), 32'(b_addr[v.bank]), 32'(v.addr));
      if (v.wr) check($sformatf("v%0d_req_data", i), 32'(b_data[v.bank]), 32'(v.wdata));
      b_ready[v.bank] = 1'b1;
      tick();
      b_ready[v.bank] = 1'b0;
      check($sformatf("v%0d_req_cleared", i), 32'(b_valid), 32'd0);
      b_resp_valid[v.bank] = 1'b1; b_resp_data[v.bank] = v.resp;
      tick();
      b_resp_valid[v.bank] = 1'b0; b_resp_data[v.bank] = '0;
      check($sformatf("v%0d_rd_ready", i), 32'(rd_ready), v.wr ? 32'd0 : 32'(onehot));
      check($sformatf("v%0d_wr_ready", i), 32'(wr_ready), v.wr ? 32'(onehot) : 32'd0);
      if (!v.wr) check($sformatf("v%0d_rd_data", i), 32'(rd_data[v.c]), 32'(v.resp));
      tick();
      check($sformatf("v%0d_ready_held", i), 32'(rd_ready | wr_ready), 32'(onehot));
      rd_valid[v.c] = 1'b0; wr_valid[v.c] = 1'b0;
      tick();
      check($sformatf("v%0d_ready_drop", i), 32'(rd_ready | wr_ready), 32'd0);
      if (!v.wr) check($sformatf("v%0d_rd_data_kept", i), 32'(rd_data[v.c]), 32'(v.resp));
    end

    // Contention on bank 0: c0, c2, c5 (bank-0 pointer currently at c7)
    rd_valid[0] = 1'b1; rd_addr[0] = 8'h10;
    rd_valid[2] = 1'b1; rd_addr[2] = 8'h20;
    rd_valid[5] = 1'b1; rd_addr[5] = 8'h40;
    tick();
    serve(0, 8'h10, 8'hA0, "cont_c0");
    check("cont_c0_ready", 32'(rd_ready), 32'h01);
    rd_valid[0] = 1'b0;
    serve(0, 8'h20, 8'hA2, "cont_c2");
    check("cont_c2_ready", 32'(rd_ready), 32'h04);
    rd_valid[2] = 1'b0;
    serve(0, 8'h40, 8'hA5, "cont_c5");
    check("cont_c5_ready", 32'(rd_ready), 32'h20);
    check("cont_c5_data", 32'(rd_data[5]), 32'hA5);
    rd_valid[5] = 1'b0;
    tick();
    // Pointer now at c5: c0 must beat c5
    rd_valid[0] = 1'b1;
    rd_valid[5] = 1'b1;
    tick();
    serve(0, 8'h10, 8'hB0, "rr2_c0");
    check("rr2_c0_ready", 32'(rd_ready), 32'h01);
    rd_valid[0] = 1'b0;
    serve(0, 8'h40, 8'hB5, "rr2_c5");
    check("rr2_c5_ready", 32'(rd_ready), 32'h20);
    rd_valid[5] = 1'b0;
    tick();

    // Parallel banks: c1 store to bank 0, c3 load from bank 1
    wr_valid[1] = 1'b1; wr_addr[1] = 8'h02; wr_data[1] = 8'h11;
    rd_valid[3] = 1'b1; rd_addr[3] = 8'h03;
    tick();
    check("par_req_valid", 32'(b_valid), 32'h3);
    check("par_req_write", 32'(b_write), 32'h1);
    check("par_b0_data", 32'(b_data[0]), 32'h11);
    b_ready = 2'b11;
    tick();
    b_ready = 2'b00;
    b_resp_valid = 2'b11; b_resp_data[1] = 8'hD3;
    tick();
    b_resp_valid = 2'b00; b_resp_data[1] = '0;
    check("par_wr_ready", 32'(wr_ready), 32'h02);
    check("par_rd_ready", 32'(rd_ready), 32'h08);
    check("par_rd_data", 32'(rd_data[3]), 32'hD3);
    wr_valid[1] = 1'b0; rd_valid[3] = 1'b0;
    tick();

    // Backpressure on bank 1 with a second requester waiting
    rd_valid[4] = 1'b1; rd_addr[4] = 8'h21;
    tick();
    rd_valid[6] = 1'b1; rd_addr[6] = 8'h31;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {23'd0, b_valid[1], b_addr[1]}, {23'd0, 1'b1, 8'h21});
    end
    b_ready[1] = 1'b1;
    tick();
    b_ready[1] = 1'b0;
    tick();
    check("bp_no_regrant", 32'(b_valid), 32'd0);
    b_resp_valid[1] = 1'b1; b_resp_data[1] = 8'h44;
    tick();
    b_resp_valid[1] = 1'b0;
    check("bp_c4_ready", 32'(rd_ready), 32'h10);
    rd_valid[4] = 1'b0;
    serve(1, 8'h31, 8'h66, "bp_c6");
    check("bp_c6_ready", 32'(rd_ready), 32'h40);
    rd_valid[6] = 1'b0;
    tick();

    // Read and write from c2 together, then reset while the write is in WAIT
    rd_valid[2] = 1'b1; rd_addr[2] = 8'h08;
    wr_valid[2] = 1'b1; wr_addr[2] = 8'h09; wr_data[2] = 8'h99;
    tick();
    check("rw_read_first", {30'd0, b_valid}, 32'h1);
    check("rw_read_write_bit", 32'(b_write[0]), 32'd0);
    serve(0, 8'h08, 8'h42, "rw_read");
    check("rw_rd_ready", 32'(rd_ready), 32'h04);
    check("rw_wr_not_ready", 32'(wr_ready), 32'h00);
    tick();
    check("rw_write_held_off", 32'(b_valid), 32'd0);
    rd_valid[2] = 1'b0;
    tick();
    check("rw_rd_ready_drop", 32'(rd_ready), 32'd0);
    tick();
    check("rw_write_req", {22'd0, b_valid[1], b_write[1], b_addr[1]}, {22'd0, 1'b1, 1'b1, 8'h09});
    check("rw_write_data", 32'(b_data[1]), 32'h99);
    b_ready[1] = 1'b1;
    tick();
    b_ready[1] = 1'b0;
    reset = 1'b1;
    wr_valid[2] = 1'b0;
    tick();
    reset = 1'b0;
    check("rw_rst_rd_data", 32'(rd_data[2]), 32'd0);
    b_resp_valid[1] = 1'b1; b_resp_data[1] = 8'hEE;
    tick();
    b_resp_valid[1] = 1'b0;
    tick();
    check("rw_stray_wr_ready", 32'(wr_ready), 32'd0);
    check("rw_stray_rd_ready", 32'(rd_ready), 32'd0);
    check("rw_stray_req", 32'(b_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
